odt_uart_bridge: RTL and testbench

- Console-side peer of the DCJ11 ODT byte port (rrdy/rstb, wrdy/wstb, shared 8-bit ad bus).
- Converts bytes the CPU writes to XBUF into 8N1 serial on txd.
- Converts 8N1 serial received on rxd into bytes offered to the CPU via RBUF.
- Sits between the bus-interface top and the board USB-UART pins. Runs on the board clock.

---
 rtl/odt_uart_bridge.sv | 262 ++++++++++++++++++++++++++
 tb/tb_odt_uart_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/odt_uart_bridge.sv
// rtl/odt_uart_bridge.sv - ODT byte port peer bridging CPU XBUF/RBUF traffic to an 8N1 UART
// Capture/TX path serialises CPU bytes; RX path deserialises into a FIFO offered back on ad.
module odt_uart_bridge #(
  parameter int CLKS_PER_BIT = 234,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rrdy,
  input  logic       rstb,
  output logic       wrdy,
  input  logic       wstb,
  inout  wire  [7:0] ad,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic       {C_READY, C_BUSY} cap_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [1:0] {W_IDLE, W_OFFER, W_HOLD} wr_t;

  logic [1:0] rstb_sync_q, wstb_sync_q, rxd_sync_q;
  logic       rxd_prev_q;
  logic       rstb_s, wstb_s, rxd_s;

  cap_t          cap_q, cap_d;
  logic          cap_latch, rrdy_q, rrdy_d;
  logic [7:0]    tx_byte_q;

  tx_t           tx_q, tx_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic          txd_q, txd_d;

  rx_t           rx_q, rx_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          stop_done, rx_push, rx_drop_full, frame_err_d;
  logic          frame_err_q, rx_overrun_q;

  logic [7:0]    mem_q [RX_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          fifo_full, fifo_empty, rx_pop;

  wr_t           w_q, w_d;
  logic          ad_oe;

  assign rstb_s = rstb_sync_q[1];
  assign wstb_s = wstb_sync_q[1];
  assign rxd_s  = rxd_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rstb_sync_q <= 2'b00;
      wstb_sync_q <= 2'b00;
      rxd_sync_q  <= 2'b11;
      rxd_prev_q  <= 1'b1;
    end else begin
      rstb_sync_q <= {rstb_sync_q[0], rstb};
      wstb_sync_q <= {wstb_sync_q[0], wstb};
      rxd_sync_q  <= {rxd_sync_q[0], rxd};
      rxd_prev_q  <= rxd_s;
    end
  end

  // Capture FSM: rrdy is registered so it is low throughout reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q  <= C_READY;
      rrdy_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      rrdy_q <= rrdy_d;
    end
  end

  always_comb begin
    cap_d = cap_q;
    case (cap_q)
      C_READY: if (rstb_s && tx_q == T_IDLE) cap_d = C_BUSY;
      C_BUSY:  if (!rstb_s && tx_q == T_IDLE) cap_d = C_READY;
      default: cap_d = C_READY;
    endcase
  end

  always_comb begin
    cap_latch = (cap_q == C_READY) && rstb_s && (tx_q == T_IDLE);
    rrdy_d    = (cap_d == C_READY);
  end

  always_ff @(posedge clk) begin
    if (cap_latch) tx_byte_q <= ad;
  end

  // TX FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= T_IDLE;
      tx_cnt_q <= '0;
      tx_idx_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_q     <= tx_d;
      tx_cnt_q <= tx_cnt_d;
      tx_idx_q <= tx_idx_d;
      txd_q    <= txd_d;
    end
  end

  always_comb begin
    tx_d     = tx_q;
    tx_cnt_d = tx_cnt_q - CW'(1);
    tx_idx_d = tx_idx_q;
    case (tx_q)
      T_IDLE: begin
        tx_cnt_d = tx_cnt_q;
        if (cap_latch) begin
          tx_d     = T_START;
          tx_cnt_d = CNT_FULL;
        end
      end
      T_START: if (tx_cnt_q == '0) begin
        tx_d     = T_DATA;
        tx_cnt_d = CNT_FULL;
        tx_idx_d = 3'd0;
      end
      T_DATA: if (tx_cnt_q == '0) begin
        tx_cnt_d = CNT_FULL;
        if (tx_idx_q == 3'd7) tx_d = T_STOP;
        else tx_idx_d = tx_idx_q + 3'd1;
      end
      T_STOP: if (tx_cnt_q == '0) tx_d = T_IDLE;
      default: tx_d = T_IDLE;
    endcase
  end

  always_comb begin
    case (tx_d)
      T_START: txd_d = 1'b0;
      T_DATA:  txd_d = tx_byte_q[tx_idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  // RX FSM: start is qualified at half-bit, then every bit is sampled mid-cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q         <= R_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_q        <= rx_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_shift_q  <= rx_shift_d;
      frame_err_q <= frame_err_d;
      if (rx_drop_full) rx_overrun_q <= 1'b1;
    end
  end

  always_comb begin
    rx_d       = rx_q;
    rx_cnt_d   = rx_cnt_q - CW'(1);
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    case (rx_q)
      R_IDLE: begin
        rx_cnt_d = rx_cnt_q;
        if (rxd_prev_q && !rxd_s) begin
          rx_d     = R_START;
          rx_cnt_d = CNT_HALF;
        end
      end
      R_START: if (rx_cnt_q == '0) begin
        if (rxd_s) rx_d = R_IDLE;
        else begin
          rx_d     = R_DATA;
          rx_cnt_d = CNT_FULL;
          rx_idx_d = 3'd0;
        end
      end
      R_DATA: if (rx_cnt_q == '0) begin
        rx_shift_d = {rxd_s, rx_shift_q[7:1]};
        rx_cnt_d   = CNT_FULL;
        if (rx_idx_q == 3'd7) rx_d = R_STOP;
        else rx_idx_d = rx_idx_q + 3'd1;
      end
      R_STOP: if (rx_cnt_q == '0) rx_d = R_IDLE;
      default: rx_d = R_IDLE;
    endcase
  end

  always_comb begin
    stop_done    = (rx_q == R_STOP) && (rx_cnt_q == '0);
    rx_push      = stop_done && rxd_s && !fifo_full;
    rx_drop_full = stop_done && rxd_s && fifo_full;
    frame_err_d  = stop_done && !rxd_s;
  end

  // RX FIFO
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (rx_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (rx_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) mem_q[wptr_q[AW-1:0]] <= rx_shift_q;
  end

  // Offer FSM
  always_ff @(posedge clk) begin
    if (rst) w_q <= W_IDLE;
    else     w_q <= w_d;
  end

  always_comb begin
    w_d = w_q;
    case (w_q)
      W_IDLE:  if (!fifo_empty && !rstb_s && cap_q == C_READY) w_d = W_OFFER;
      W_OFFER: begin
        if (rstb_s)      w_d = W_IDLE;
        else if (wstb_s) w_d = W_HOLD;
      end
      W_HOLD:  if (!wstb_s) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  // The bus is released the moment a CPU strobe is seen, even before the state moves.
  always_comb begin
    wrdy   = (w_q == W_OFFER);
    ad_oe  = ((w_q == W_OFFER) || (w_q == W_HOLD)) && !rstb_s;
    rx_pop = (w_q == W_HOLD) && !wstb_s;
  end

  assign ad         = ad_oe ? mem_q[rptr_q[AW-1:0]] : {8{1'bz}};
  assign rrdy       = rrdy_q;
  assign txd        = txd_q;
  assign rx_overrun = rx_overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_odt_uart_bridge.sv
// tb/tb_odt_uart_bridge.sv - scoreboard bench for odt_uart_bridge
module tb_odt_uart_bridge;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, rstb, wstb, rxd, ad_en;
  logic [7:0] ad_drv;
  wire  [7:0] ad;
  wire  rrdy, wrdy, txd, rx_overrun, frame_err;

  always #5 clk = ~clk;

  assign ad = ad_en ? ad_drv : {8{1'bz}};
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (ad[g]);
  end

  odt_uart_bridge #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rrdy(rrdy), .rstb(rstb), .wrdy(wrdy), .wstb(wstb),
    .ad(ad), .txd(txd), .rxd(rxd), .rx_overrun(rx_overrun), .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_wrdy = 1'b0;
  logic [7:0] rx_e;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int sel, input logic v, input string nm);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clk);
      if (((sel == 0) ? wrdy : rrdy) === v) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: timeout waiting for level %0d", nm, v);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(CPB);
    end
    rxd = stop;
    cyc(CPB);
    rxd = 1'b1;
    cyc(2);
  endtask

  task automatic handshake(input logic [7:0] e);
    wait_sig(0, 1'b1, "offer");
    cyc(1);
    wstb = 1'b1;
    wait_sig(0, 1'b0, "wrdy_fall");
    check("hold_ad", ad, e);
    cyc(1);
    wstb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hold_until_wstb_low", ad, e);
    @(posedge clk);
    @(negedge clk);
    check("ad_released", ad, 8'hFF);
    check("wrdy_idle", wrdy, 1'b0);
    cyc(1);
  endtask

  always @(negedge clk) if (frame_err) fe_cnt++;

  // Offer monitor: every rising wrdy must present the next expected RX byte.
  always @(negedge clk) begin
    if (mon_en && wrdy && !prev_wrdy) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL offer: got unexpected byte %02h, expected none", ad);
      end else begin
        rx_e = exp_rx.pop_front();
        check("offer_ad", ad, rx_e);
      end
    end
    prev_wrdy <= wrdy;
  end

  // TX monitor: checks every cycle of the 10-bit frame against the expected waveform.
  initial begin : tx_mon
    logic [7:0] e, got;
    logic [9:0] frm;
    int bad;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_frame: got unexpected frame, expected none");
          e = 8'h00;
        end else begin
          e = exp_tx.pop_front();
        end
        frm = {1'b1, e, 1'b0};
        bad = 0;
        got = 8'h00;
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (txd !== frm[c / CPB]) bad++;
          if (c % CPB == CPB / 2 && c >= CPB && c < 9 * CPB) got[c / CPB - 1] = txd;
        end
        check("tx_byte", got, e);
        check("tx_timing_bad_cycles", bad, 0);
        @(negedge clk);
        check("tx_idle_after_stop", txd, 1'b1);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin : stim
    int f0, n;
    rst = 1'b1; rstb = 1'b0; wstb = 1'b0; rxd = 1'b1; ad_en = 1'b0; ad_drv = 8'h00;
    cyc(3);
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_rrdy", rrdy, 1'b0);
    check("rst_wrdy", wrdy, 1'b0);
    check("rst_ad", ad, 8'hFF);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check("rrdy_before_first_edge", rrdy, 1'b0);
    @(negedge clk);
    check("rrdy_after_release", rrdy, 1'b1);
    cyc(1);

    // Abort a TX frame and a partial RX byte with a 3-cycle reset.
    ad_drv = 8'hAA; ad_en = 1'b1; rstb = 1'b1;
    wait_sig(1, 1'b0, "capture_aa");
    cyc(1);
    rstb = 1'b0; ad_en = 1'b0;
    rxd = 1'b0; cyc(CPB);
    rxd = 1'b1; cyc(CPB);
    rxd = 1'b0; cyc(4);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_txd", txd, 1'b1);
      check("midrst_rrdy", rrdy, 1'b0);
      check("midrst_wrdy", wrdy, 1'b0);
      check("midrst_ad", ad, 8'hFF);
    end
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    check("midrst_rrdy_release", rrdy, 1'b1);
    cyc(20);
    mon_en = 1'b1;

    // TX 0x55 and rrdy throttling across the whole frame.
    exp_tx.push_back(8'h55);
    ad_drv = 8'h55; ad_en = 1'b1; rstb = 1'b1;
    wait_sig(1, 1'b0, "capture_55");
    rstb = 1'b0; ad_en = 1'b0;
    n = 0;
    while (n < 400 && rrdy == 1'b0) begin
      @(negedge clk);
      n++;
    end
    check("rrdy_low_cycles", n, 81);
    cyc(10);

    // RX 0xA3 offer and handshake.
    exp_rx.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    handshake(8'hA3);
    cyc(20);
    check("fifo_empty_no_offer", wrdy, 1'b0);

    // Overrun: five bytes into four entries.
    for (int i = 1; i <= 4; i++) exp_rx.push_back(8'(i));
    for (int i = 1; i <= 4; i++) send_rx(8'(i), 1'b1);
    check("overrun_before_5th", rx_overrun, 1'b0);
    send_rx(8'h05, 1'b1);
    check("overrun_set", rx_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) handshake(8'(i));
    cyc(30);
    check("byte5_lost", wrdy, 1'b0);

    // Framing error and false start.
    f0 = fe_cnt;
    send_rx(8'h3C, 1'b0);
    cyc(10);
    check("frame_err_pulses", fe_cnt - f0, 1);
    check("no_offer_bad_stop", wrdy, 1'b0);
    f0 = fe_cnt;
    rxd = 1'b0; cyc(3);
    rxd = 1'b1; cyc(30);
    check("glitch_no_err", fe_cnt - f0, 0);
    check("glitch_no_offer", wrdy, 1'b0);

    // Bus conflict: CPU transmits while 0x7E is being offered.
    exp_rx.push_back(8'h7E);
    exp_rx.push_back(8'h7E);
    send_rx(8'h7E, 1'b1);
    wait_sig(0, 1'b1, "offer_7e");
    cyc(1);
    exp_tx.push_back(8'h41);
    ad_drv = 8'h41; ad_en = 1'b1; rstb = 1'b1;
    wait_sig(0, 1'b0, "conflict_wrdy_drop");
    check("conflict_ad", ad, 8'h41);
    wait_sig(1, 1'b0, "capture_41");
    cyc(1);
    rstb = 1'b0; ad_en = 1'b0;
    handshake(8'h7E);
    cyc(30);

    check("exp_tx_drained", exp_tx.size(), 0);
    check("exp_rx_drained", exp_rx.size(), 0);
    check("overrun_sticky", rx_overrun, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
